// File: rtl/stream_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on a valid/ready handshake
// and shifts them out one bit per clock, gapless when words arrive back to back.
//
// state | meaning
// IDLE  | no word loaded, ser_out holds IDLE_BIT, ready for a word
// SHIFT | word in shreg, cnt = index of the bit currently on ser_out
module stream_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last_bit;
    logic             accept;

    assign last_bit   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign load_ready = (state == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;
    assign bit_valid  = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign word_done  = last_bit;
    assign ser_out    = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
                                         : IDLE_BIT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A load on the last bit takes priority so the next word follows with no gap.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = SHIFT;
            shreg_nxt = load_data;
            cnt_nxt   = '0;
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state_nxt = IDLE;
            end else begin
                shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[WIDTH-1:1]};
                cnt_nxt   = cnt + CW'(1);
            end
        end
    end

endmodule
